// File: rtl/standcell_delay_monitor.sv
// Measures the propagation delay (in U cycles) of an inverting standard-cell
// model by timing each D edge to the matching _Q edge; keeps last/worst values and error flags.
module standcell_delay_monitor #(
    parameter int CNTW = 8,
    parameter int SWW  = 8
) (
    input  logic            U,
    input  logic            RESET,
    input  logic            CLR,
    input  logic            D,
    input  logic            _Q,
    output logic            meas_valid,
    output logic            meas_hl,
    output logic [CNTW-1:0] tphl_last,
    output logic [CNTW-1:0] tplh_last,
    output logic [CNTW-1:0] tphl_max,
    output logic [CNTW-1:0] tplh_max,
    output logic [SWW-1:0]  swallow_cnt,
    output logic            timeout,
    output logic            spurious
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FALL = 2'd1,
        WAIT_RISE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
    localparam logic [SWW-1:0]  SW_MAX  = {SWW{1'b1}};

    logic d_s_reg, q_s_reg, d_prev_reg, q_prev_reg, primed_reg;

    state_t          state_reg, state_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;
    logic            valid_reg, valid_next;
    logic            hl_reg, hl_next;
    logic [SWW-1:0]  swallow_reg, swallow_next;
    logic            timeout_reg, timeout_next;
    logic            spurious_reg, spurious_next;

    // Until primed, the previous-sample registers copy the port so the first
    // sample after reset is a reference and cannot produce an edge.
    always_ff @(posedge U) begin
        if (RESET) begin
            d_s_reg    <= 1'b0;
            q_s_reg    <= 1'b0;
            d_prev_reg <= 1'b0;
            q_prev_reg <= 1'b0;
            primed_reg <= 1'b0;
        end else begin
            d_s_reg    <= D;
            q_s_reg    <= _Q;
            d_prev_reg <= primed_reg ? d_s_reg : D;
            q_prev_reg <= primed_reg ? q_s_reg : _Q;
            primed_reg <= 1'b1;
        end
    end

    logic            d_edge, q_edge, waiting, q_good, q_bad, done;
    logic [CNTW-1:0] meas_value;
    logic [1:0]      dir_done;

    assign d_edge     = d_s_reg != d_prev_reg;
    assign q_edge     = q_s_reg != q_prev_reg;
    assign waiting    = state_reg != IDLE;
    assign q_good     = waiting && q_edge && (q_s_reg == (state_reg == WAIT_RISE));
    assign q_bad      = waiting && q_edge && (q_s_reg != (state_reg == WAIT_RISE));
    // A completion seen once the counter has saturated counts as a timeout.
    assign done       = q_good && (cnt_reg != CNT_MAX);
    assign meas_value = cnt_reg + CNTW'(1);
    assign dir_done[0] = done && (state_reg == WAIT_FALL);
    assign dir_done[1] = done && (state_reg == WAIT_RISE);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        valid_next    = 1'b0;
        hl_next       = hl_reg;
        swallow_next  = CLR ? '0 : swallow_reg;
        timeout_next  = CLR ? 1'b0 : timeout_reg;
        spurious_next = CLR ? 1'b0 : spurious_reg;

        if (waiting) begin
            if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNTW'(1);
            end
            if (done) begin
                valid_next = 1'b1;
                hl_next    = (state_reg == WAIT_FALL);
                state_next = IDLE;
            end else if (d_edge) begin
                swallow_next = CLR ? SWW'(1) :
                               ((swallow_reg == SW_MAX) ? swallow_reg : swallow_reg + SWW'(1));
            end else if (cnt_reg == CNT_MAX) begin
                timeout_next = 1'b1;
                state_next   = IDLE;
            end
            if (q_bad) begin
                spurious_next = 1'b1;
            end
        end else if (q_edge && !d_edge) begin
            spurious_next = 1'b1;
        end

        // A D edge always (re)starts timing after any completion above.
        if (d_edge) begin
            cnt_next = '0;
            if (q_s_reg == ~d_s_reg) begin
                state_next = IDLE;
            end else begin
                state_next = d_s_reg ? WAIT_FALL : WAIT_RISE;
            end
        end
    end

    always_ff @(posedge U) begin
        if (RESET) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            valid_reg    <= 1'b0;
            hl_reg       <= 1'b0;
            swallow_reg  <= '0;
            timeout_reg  <= 1'b0;
            spurious_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            valid_reg    <= valid_next;
            hl_reg       <= hl_next;
            swallow_reg  <= swallow_next;
            timeout_reg  <= timeout_next;
            spurious_reg <= spurious_next;
        end
    end

    // Per-direction statistics: index 0 is tphl, index 1 is tplh.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dir
            logic [CNTW-1:0] last_reg, last_next;
            logic [CNTW-1:0] max_reg, max_next;

            always_comb begin
                last_next = last_reg;
                max_next  = CLR ? '0 : max_reg;
                if (dir_done[gi]) begin
                    last_next = meas_value;
                    if (CLR || (meas_value > max_reg)) begin
                        max_next = meas_value;
                    end
                end
            end

            always_ff @(posedge U) begin
                if (RESET) begin
                    last_reg <= '0;
                    max_reg  <= '0;
                end else begin
                    last_reg <= last_next;
                    max_reg  <= max_next;
                end
            end
        end
    endgenerate

    assign meas_valid  = valid_reg;
    assign meas_hl     = hl_reg;
    assign tphl_last   = g_dir[0].last_reg;
    assign tplh_last   = g_dir[1].last_reg;
    assign tphl_max    = g_dir[0].max_reg;
    assign tplh_max    = g_dir[1].max_reg;
    assign swallow_cnt = swallow_reg;
    assign timeout     = timeout_reg;
    assign spurious    = spurious_reg;

endmodule

// File: tb/tb_standcell_delay_monitor.sv
// Directed bench for standcell_delay_monitor: hand-timed D/_Q waveforms with
// hand-computed delays, plus a CNTW=6 instance for the timeout path.
module tb_standcell_delay_monitor;

    logic       u = 1'b0;
    logic       reset, clr, d, q;
    logic       clr6, d6, q6;

    logic       mv, hl;
    logic [7:0] tphl_last, tplh_last, tphl_max, tplh_max, sw_cnt;
    logic       to, spur;

    logic       mv6, hl6;
    logic [5:0] tphl_last6, tplh_last6, tphl_max6, tplh_max6;
    logic [7:0] sw_cnt6;
    logic       to6, spur6;

    int tests_run = 0;
    int fail_cnt  = 0;
    int valid_cnt = 0;
    int valid6_cnt = 0;
    int vc_snap;

    always #5 u = ~u;

    standcell_delay_monitor #(.CNTW(8), .SWW(8)) dut (
        .U(u), .RESET(reset), .CLR(clr), .D(d), ._Q(q),
        .meas_valid(mv), .meas_hl(hl),
        .tphl_last(tphl_last), .tplh_last(tplh_last),
        .tphl_max(tphl_max), .tplh_max(tplh_max),
        .swallow_cnt(sw_cnt), .timeout(to), .spurious(spur)
    );

    standcell_delay_monitor #(.CNTW(6), .SWW(8)) dut6 (
        .U(u), .RESET(reset), .CLR(clr6), .D(d6), ._Q(q6),
        .meas_valid(mv6), .meas_hl(hl6),
        .tphl_last(tphl_last6), .tplh_last(tplh_last6),
        .tphl_max(tphl_max6), .tplh_max(tplh_max6),
        .swallow_cnt(sw_cnt6), .timeout(to6), .spurious(spur6)
    );

    always @(negedge u) begin
        if (mv)  valid_cnt++;
        if (mv6) valid6_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge u);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; d = 1'b0; q = 1'b1;
        clr6 = 1'b0; d6 = 1'b0; q6 = 1'b1;
        tick(3);
        check_eq("rst_tphl_last", 32'(tphl_last), 0);
        check_eq("rst_tplh_max", 32'(tplh_max), 0);
        check_eq("rst_swallow", 32'(sw_cnt), 0);
        check_eq("rst_mv", 32'(mv), 0);
        reset = 1'b0;
        tick(4);
        check_eq("prime_spurious", 32'(spur), 0);

        // T1: tphl = 8
        d = 1'b1; tick(8); q = 1'b0;
        tick(1); check_eq("t1_mv_early", 32'(mv), 0);
        tick(1);
        check_eq("t1_mv", 32'(mv), 1);
        check_eq("t1_hl", 32'(hl), 1);
        check_eq("t1_tphl_last", 32'(tphl_last), 8);
        check_eq("t1_tphl_max", 32'(tphl_max), 8);
        tick(1);
        check_eq("t1_mv_pulse", 32'(mv), 0);
        check_eq("t1_valid_cnt", 32'(valid_cnt), 1);

        // T2: tplh = 32
        tick(3); d = 1'b0; tick(32); q = 1'b1; tick(2);
        check_eq("t2_hl", 32'(hl), 0);
        check_eq("t2_tplh_last", 32'(tplh_last), 32);
        check_eq("t2_tplh_max", 32'(tplh_max), 32);
        check_eq("t2_tphl_last", 32'(tphl_last), 8);
        tick(1);
        check_eq("t2_valid_cnt", 32'(valid_cnt), 2);

        // T3: swallowed 5-cycle pulse, then a full one
        tick(3); d = 1'b1; tick(5); d = 1'b0; tick(4);
        check_eq("t3_swallow", 32'(sw_cnt), 1);
        check_eq("t3_no_valid", 32'(valid_cnt), 2);
        d = 1'b1; tick(8); q = 1'b0; tick(2);
        check_eq("t3_mv", 32'(mv), 1);
        check_eq("t3_tphl_last", 32'(tphl_last), 8);

        // T6: tphl_max=20, then CLR on the recording cycle of a 5-cycle completion
        d = 1'b0; tick(4); q = 1'b1; tick(3);
        d = 1'b1; tick(20); q = 1'b0; tick(3);
        check_eq("t6_tphl_max20", 32'(tphl_max), 20);
        d = 1'b0; tick(4); q = 1'b1; tick(3);
        d = 1'b1; tick(5); q = 1'b0; tick(1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check_eq("t6_mv", 32'(mv), 1);
        check_eq("t6_tphl_last", 32'(tphl_last), 5);
        check_eq("t6_tphl_max", 32'(tphl_max), 5);
        check_eq("t6_swallow", 32'(sw_cnt), 0);
        check_eq("t6_tplh_max", 32'(tplh_max), 0);

        // Two swallows, then CLR coincident with a third
        tick(2);
        d = 1'b0; tick(3); d = 1'b1; tick(3);
        d = 1'b0; tick(3); d = 1'b1; tick(3);
        check_eq("sw_two", 32'(sw_cnt), 2);
        d = 1'b0; tick(3); d = 1'b1; tick(1);
        clr = 1'b1; tick(1); clr = 1'b0;
        check_eq("sw_clr_coinc", 32'(sw_cnt), 1);
        tick(2);

        // T5: spurious _Q pulse with D steady low
        d = 1'b0; tick(2); q = 1'b1; tick(4);
        check_eq("t5_tplh_last", 32'(tplh_last), 2);
        check_eq("t5_spur_before", 32'(spur), 0);
        q = 1'b0; tick(1); q = 1'b1; tick(3);
        check_eq("t5_spurious", 32'(spur), 1);

        // RESET in the middle of WAIT_RISE
        d = 1'b1; tick(2); q = 1'b0; tick(3);
        d = 1'b0; tick(3);
        reset = 1'b1; q = 1'b1; tick(2);
        check_eq("rst2_tphl_max", 32'(tphl_max), 0);
        check_eq("rst2_tphl_last", 32'(tphl_last), 0);
        check_eq("rst2_hl", 32'(hl), 0);
        check_eq("rst2_swallow", 32'(sw_cnt), 0);
        check_eq("rst2_spurious", 32'(spur), 0);
        vc_snap = valid_cnt;
        reset = 1'b0; tick(5);
        check_eq("rst2_no_edge", 32'(spur), 0);
        check_eq("rst2_tplh_last", 32'(tplh_last), 0);
        check_eq("rst2_no_valid", 32'(valid_cnt), 32'(vc_snap));
        d = 1'b1; tick(6); q = 1'b0; tick(2);
        check_eq("rst2_mv", 32'(mv), 1);
        check_eq("rst2_tphl_last6", 32'(tphl_last), 6);

        // T4: CNTW=6 timeout at counter 63
        d6 = 1'b1; tick(65);
        check_eq("t4_to_early", 32'(to6), 0);
        tick(1);
        check_eq("t4_timeout", 32'(to6), 1);
        check_eq("t4_no_valid", 32'(valid6_cnt), 0);
        check_eq("t4_tphl_last", 32'(tphl_last6), 0);
        q6 = 1'b0; tick(3);
        check_eq("t4_idle_spur", 32'(spur6), 1);
        clr6 = 1'b1; tick(1); clr6 = 1'b0;
        check_eq("t4_clr_to", 32'(to6), 0);
        check_eq("t4_clr_spur", 32'(spur6), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
